// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the funct3 legality check used at request accept.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic funct3_legal(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic       is64);
        logic ok;
        ok = 1'b0;
        if (write) begin
            ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW) ||
                 (is64 && (funct3 == F3_SD));
        end else begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                F3_LD, F3_LWU:                       ok = is64;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: byte enables and shifted store data for both
// beats, plus merge of up to two read beats with sign/zero extension.
module lsu_align #(
    parameter  int DATA_SIZE = 32,
    localparam int BYTES     = DATA_SIZE / 8,
    localparam int OFF       = $clog2(BYTES)
) (
    input  logic [OFF-1:0]       offset,
    input  logic [1:0]           size_log2,
    input  logic                 is_unsigned,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [DATA_SIZE-1:0] beat0_rd,
    input  logic [DATA_SIZE-1:0] beat1_rd,
    output logic [BYTES-1:0]     byte_en0,
    output logic [BYTES-1:0]     byte_en1,
    output logic [DATA_SIZE-1:0] wr_data0,
    output logic [DATA_SIZE-1:0] wr_data1,
    output logic [DATA_SIZE-1:0] rd_data
);

    // Left-justify the loaded field, then shift back arithmetically or logically.
    function automatic logic [DATA_SIZE-1:0] extend_load(input logic [DATA_SIZE-1:0] raw,
                                                         input logic [1:0]           sz,
                                                         input logic                 uns);
        int                          sh;
        logic signed [DATA_SIZE-1:0] left;
        sh = DATA_SIZE - (8 << sz);
        if (sh < 0) sh = 0;
        left = $signed(raw << sh);
        if (uns) return $unsigned(left) >> sh;
        return left >>> sh;
    endfunction

    int                       nbytes;
    logic [2*BYTES-1:0]       lane_mask;
    logic [2*DATA_SIZE-1:0]   wr_wide;
    logic [2*DATA_SIZE-1:0]   rd_wide;

    // Two-word-wide shifts: the upper word is exactly what spills into beat 1.
    always_comb begin
        nbytes = 1 << size_log2;
        if (nbytes > BYTES) nbytes = BYTES;
        lane_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < nbytes) lane_mask[i] = 1'b1;
        end
        lane_mask = lane_mask << offset;
        wr_wide   = {{DATA_SIZE{1'b0}}, wr_data} << {offset, 3'b000};
        rd_wide   = {beat1_rd, beat0_rd} >> {offset, 3'b000};
        rd_data   = extend_load(rd_wide[DATA_SIZE-1:0], size_log2, is_unsigned);
    end

    assign byte_en0 = lane_mask[BYTES-1:0];
    assign byte_en1 = lane_mask[2*BYTES-1:BYTES];
    assign wr_data0 = wr_wide[DATA_SIZE-1:0];
    assign wr_data1 = wr_wide[2*DATA_SIZE-1:DATA_SIZE];

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request/response handshake in front of a waited memory
// port, with lane alignment, load extension and optional two-beat splitting.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_SIZE        = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_funct3,
    input  logic [DATA_SIZE-1:0]   req_addr,
    input  logic [DATA_SIZE-1:0]   req_wr_data,
    output logic                   resp_valid,
    output logic [DATA_SIZE-1:0]   resp_rd_data,
    output logic                   resp_misaligned,
    output logic                   resp_err,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [DATA_SIZE-1:0]   mem_addr,
    output logic [DATA_SIZE/8-1:0] mem_byte_en,
    output logic [DATA_SIZE-1:0]   mem_wr_data,
    input  logic [DATA_SIZE-1:0]   mem_rd_data,
    input  logic                   mem_ack,
    input  logic                   mem_err
);

    localparam int BYTES = DATA_SIZE / 8;
    localparam int OFF   = $clog2(BYTES);

    lsu_state_e             state, state_nxt;
    logic                   accept, req_legal, req_cross, beat_active, beat_ack;
    logic                   req_write_p0, cross_p0;
    logic [2:0]             funct3_p0;
    logic [DATA_SIZE-1:0]   req_addr_p0, req_wr_data_p0, base_p0;
    logic [DATA_SIZE-1:0]   beat0_rd_p1, beat0_rd_sel, ld_data;
    logic [DATA_SIZE-1:0]   wr_data0, wr_data1;
    logic [BYTES-1:0]       byte_en0, byte_en1;

    assign req_ready   = (state == ST_IDLE);
    assign accept      = req_valid && req_ready;
    assign resp_valid  = (state == ST_RESP);
    assign beat_active = (state == ST_BEAT0) || (state == ST_BEAT1);
    assign beat_ack    = beat_active && mem_ack;
    assign base_p0     = {req_addr_p0[DATA_SIZE-1:OFF], {OFF{1'b0}}};

    always_comb begin
        req_legal = funct3_legal(req_write, req_funct3, DATA_SIZE == 64);
        req_cross = (int'(req_addr[OFF-1:0]) + (1 << req_funct3[1:0])) > BYTES;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!req_legal || (req_cross && (ALLOW_MISALIGNED == 1'b0)))
                        state_nxt = ST_RESP;
                    else
                        state_nxt = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (mem_ack) begin
                    if (mem_err)       state_nxt = ST_RESP;
                    else if (cross_p0) state_nxt = ST_BEAT1;
                    else               state_nxt = ST_RESP;
                end
            end
            ST_BEAT1: if (mem_ack) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are zeroed outside the beats so reset idles the whole port at once.
    always_comb begin
        mem_rd_en   = beat_active && !req_write_p0;
        mem_wr_en   = beat_active && req_write_p0;
        mem_addr    = '0;
        mem_byte_en = '0;
        mem_wr_data = '0;
        if (state == ST_BEAT0) begin
            mem_addr    = base_p0;
            mem_byte_en = byte_en0;
            mem_wr_data = wr_data0;
        end else if (state == ST_BEAT1) begin
            mem_addr    = base_p0 + DATA_SIZE'(BYTES);
            mem_byte_en = byte_en1;
            mem_wr_data = wr_data1;
        end
    end

    assign beat0_rd_sel = (state == ST_BEAT1) ? beat0_rd_p1 : mem_rd_data;

    lsu_align #(.DATA_SIZE(DATA_SIZE)) u_align (
        .offset      (req_addr_p0[OFF-1:0]),
        .size_log2   (funct3_p0[1:0]),
        .is_unsigned (funct3_p0[2]),
        .wr_data     (req_wr_data_p0),
        .beat0_rd    (beat0_rd_sel),
        .beat1_rd    (mem_rd_data),
        .byte_en0    (byte_en0),
        .byte_en1    (byte_en1),
        .wr_data0    (wr_data0),
        .wr_data1    (wr_data1),
        .rd_data     (ld_data)
    );

    // Stage p0: request capture; response flags/data latch on the final beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            req_write_p0    <= 1'b0;
            funct3_p0       <= '0;
            cross_p0        <= 1'b0;
            resp_rd_data    <= '0;
            resp_err        <= 1'b0;
            resp_misaligned <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_write_p0    <= req_write;
                funct3_p0       <= req_funct3;
                cross_p0        <= req_cross;
                resp_rd_data    <= '0;
                resp_err        <= !req_legal;
                resp_misaligned <= req_legal && req_cross && (ALLOW_MISALIGNED == 1'b0);
            end else if (beat_ack) begin
                if (mem_err)
                    resp_err <= 1'b1;
                else if (((state == ST_BEAT1) || !cross_p0) && !req_write_p0)
                    resp_rd_data <= ld_data;
            end
        end
    end

    // Stage p0/p1 data: request payload and the first read beat of a split load.
    always_ff @(posedge clock) begin
        if (accept) begin
            req_addr_p0    <= req_addr;
            req_wr_data_p0 <= req_wr_data;
        end
        if ((state == ST_BEAT0) && mem_ack) beat0_rd_p1 <= mem_rd_data;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Parametrised load/store unit sitting between the core datapath and the data memory port. It replaces the bare address/data wiring with a request/response handshake. It also adds:
- byte-lane alignment;
- sign/zero extension;
- a waited memory handshake;
- optional splitting of accesses that cross a word boundary into two aligned beats.
It supports 32- and 64-bit datapaths from one source.

Parameters:
DATA_SIZE, 32, datapath/address width; 32 or 64; BYTES = DATA_SIZE/8, OFF = log2(BYTES).
ALLOW_MISALIGNED, 1, 1: boundary-crossing access split into two beats; 0: reported as misaligned, no memory access.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  unit can accept (IDLE only)
req_write  in  1  1 store, 0 load
req_funct3  in  3  RISC-V load/store funct3
req_addr  in  DATA_SIZE  byte address
req_wr_data  in  DATA_SIZE  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
resp_rd_data  out  DATA_SIZE  extended load data
resp_misaligned  out  1  crossing access rejected (ALLOW_MISALIGNED=0)
resp_err  out  1  bus error or illegal funct3
mem_rd_en  out  1  memory read request
mem_wr_en  out  1  memory write request
mem_addr  out  DATA_SIZE  word-aligned beat address
mem_byte_en  out  BYTES  byte-lane enables
mem_wr_data  out  DATA_SIZE  lane-shifted store data
mem_rd_data  in  DATA_SIZE  memory read data, valid with mem_ack
mem_ack  in  1  beat completion
mem_err  in  1  bus error, qualified by mem_ack

Behaviour:
- Reset (async, low) drives all outputs to 0 except req_ready=1, and forces IDLE. A reset mid-operation drops mem enables immediately and discards the access.
- Size = 1<<funct3[1:0]; unsigned = funct3[2].
- Legal funct3:
  - loads: 0,1,2,4,5, plus 3 and 6 when DATA_SIZE=64;
  - stores: 0,1,2, plus 3 when DATA_SIZE=64.
- Illegal funct3: no memory access; resp_err=1 on the cycle after accept.
- Request fields are registered on accept (req_valid & req_ready).
- Offset = addr[OFF-1:0]; base = addr with low OFF bits cleared. Crossing = offset+size > BYTES.
- Misaligned but non-crossing accesses complete in one beat.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: on accept go to BEAT0; if illegal, or crossing with ALLOW_MISALIGNED=0, go to RESP.
  - BEAT0: enable held high, addr/byte_en/wr_data stable until mem_ack. On ack: mem_err → RESP with err; crossing → BEAT1; else → RESP.
  - BEAT1: address base+BYTES, modulo 2^DATA_SIZE. On ack go to RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- A mem_ack sampled outside BEAT0/BEAT1 is ignored.
- Latency: with mem_ack in the first enabled cycle, resp_valid arrives 2 cycles after accept for one beat and 3 cycles for two beats. Each extra wait cycle adds 1.
- Beat 0:
  - byte_en = ((1<<size)-1) << offset, truncated to BYTES;
  - wr_data = data << 8*offset.
- Beat 1:
  - byte_en = (1<<(offset+size-BYTES))-1;
  - wr_data = data >> 8*(BYTES-offset).
- Load assembly:
  - result = (beat0 >> 8*offset) | (beat1 << 8*(BYTES-offset));
  - then take the low 8*size bits, sign- or zero-extended to DATA_SIZE.
- Response data:
  - resp_rd_data and flags hold until the next accept;
  - resp_rd_data is 0 for stores, errors and misaligned rejects.
- resp_err and resp_misaligned are never both 1.
- A request arriving while busy is not accepted, since req_ready=0. A new request can be accepted in the cycle after RESP.

Decomposition:
- Add to macros.vh: funct3 encodings (LB..LWU, SB..SD) and FSM state constants.
- One combinational sub-module, lsu_align (parameter DATA_SIZE). It produces byte_en/wr_data for both beats and the load merge/extension, so the FSM stays in load_store_unit.

Test Plan:
- DATA_SIZE=32, sw 0x100 data 0xDEADBEEF, ack in first cycle:
  - one beat: mem_addr 0x100, byte_en 4'b1111, wr_data 0xDEADBEEF;
  - resp_valid 2 cycles after accept, err 0.
- lb 0x103 with mem_rd_data 0x80AABBCC → 0xFFFFFF80. lbu at the same address → 0x00000080. Ack delayed 3 cycles → resp_valid 5 cycles after accept.
- lw 0x102, ALLOW_MISALIGNED=1:
  - beat0 addr 0x100, byte_en 1100, rd 0x33440000;
  - beat1 addr 0x104, byte_en 0011, rd 0x00001122;
  - resp 0x11223344.
- Same lw with ALLOW_MISALIGNED=0 → no mem enables, resp_misaligned=1 one cycle after accept. sd on DATA_SIZE=32 → resp_err=1, no access.
- sh 0xFFFFFFFF, data 0xABCD:
  - beat0 addr 0xFFFFFFFC, byte_en 1000, wr_data 0xCD000000;
  - beat1 addr 0x00000000, byte_en 0001, wr_data 0x000000AB.
- Error and reset handling:
  - mem_err with ack on beat0 of a split load → resp_err=1, no beat1;
  - reset low during BEAT1 → mem_rd_en falls at once, req_ready=1 after release.
